// File: rtl/ham_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ham_pkg                                                                    |
// | Shared Hamming code geometry helpers and mode encodings for the codec.     |
// | Optional feature macro: HAM_SECDED_EN (adds the extended parity bit).      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package ham_pkg;

    localparam logic ENC = 1'b0;
    localparam logic DEC = 1'b1;

    function automatic int ham_par_w(input int data_w);
        int p;
        p = 1;
        for (int k = 1; k < 8; k++) begin
            if ((1 << p) < data_w + p + 1) p = p + 1;
        end
        return p;
    endfunction

    function automatic int ham_code_w(input int data_w);
`ifdef HAM_SECDED_EN
        return data_w + ham_par_w(data_w) + 1;
`else
        return data_w + ham_par_w(data_w);
`endif
    endfunction

    function automatic logic is_pow2(input int pos);
        return (pos != 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // Hamming position (1-based) of data bit idx: the idx-th non power of two
    function automatic int data_pos(input int idx);
        int pos;
        int cnt;
        pos = 0;
        cnt = -1;
        for (int q = 1; q < 128; q++) begin
            if (cnt < idx && !is_pow2(q)) begin
                cnt = cnt + 1;
                pos = q;
            end
        end
        return pos;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ham_syndrome.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ham_syndrome                                                               |
// | Syndrome (XOR of set-bit positions) and overall parity of a codeword.      |
// | Optional feature macro: HAM_SECDED_EN (via ham_code_w).                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ham_syndrome
    import ham_pkg::*;
#(
    parameter  int DATA_W = 11,
    localparam int PAR_W  = ham_par_w(DATA_W),
    localparam int CODE_W = ham_code_w(DATA_W)
) (
    input  logic [CODE_W-1:0] word,
    output logic [PAR_W-1:0]  syndrome,
    output logic              parity
);

    localparam int c_n_pos = DATA_W + PAR_W;

    always_comb begin
        syndrome = '0;
        for (int i = 0; i < c_n_pos; i++) begin
            if (word[i]) syndrome = syndrome ^ PAR_W'(i + 1);
        end
        parity = ^word;
    end

endmodule
`default_nettype wire

// File: rtl/ham_secded_codec.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ham_secded_codec                                                           |
// | Two-stage streaming Hamming encoder/decoder with error counters.           |
// | Optional feature macro: HAM_SECDED_EN (extended parity, double detection). |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ham_secded_codec
    import ham_pkg::*;
#(
    parameter  int DATA_W = 11,
    parameter  int CNT_W  = 16,
    localparam int PAR_W  = ham_par_w(DATA_W),
    localparam int CODE_W = ham_code_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [CODE_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_data,
    output logic              out_single,
    output logic              out_double,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  cnt_single,
    output logic [CNT_W-1:0]  cnt_double
);

    localparam int c_n_pos = DATA_W + PAR_W;

    logic              w_stall;
    logic [CODE_W-1:0] w_scatter;
    logic [CODE_W-1:0] w_s1_word;
    logic [PAR_W-1:0]  w_syn;
    logic              w_par;
    logic              r_s1_valid;
    logic              r_s1_mode;
    logic [CODE_W-1:0] r_s1_word;
    logic [PAR_W-1:0]  r_s1_syn;
    logic              r_s1_par;
    logic              w_single;
    logic              w_double;
    logic              w_flip;
    logic [CODE_W-1:0] w_fixed;
    logic [CODE_W-1:0] w_code;
    logic [DATA_W-1:0] w_payload;
    logic [CODE_W-1:0] w_result;
    logic              r_out_valid;
    logic [CODE_W-1:0] r_out_data;
    logic              r_out_single;
    logic              r_out_double;
    logic [CNT_W-1:0]  r_cnt_single;
    logic [CNT_W-1:0]  r_cnt_double;

    assign w_stall  = r_out_valid && !out_ready;
    assign in_ready = !w_stall;

    // Encode path: payload bits placed at their codeword positions, parity slots zero
    for (genvar j = 0; j < DATA_W; j++) begin : g_scatter
        localparam int c_pos = data_pos(j);
        assign w_scatter[c_pos-1] = in_data[j];
    end
    for (genvar k = 0; k < PAR_W; k++) begin : g_par_slot
        assign w_scatter[(1 << k) - 1] = 1'b0;
    end
`ifdef HAM_SECDED_EN
    assign w_scatter[CODE_W-1] = 1'b0;
`endif

    assign w_s1_word = (in_mode == DEC) ? in_data : w_scatter;

    ham_syndrome #(.DATA_W(DATA_W)) u_syndrome (
        .word     (w_s1_word),
        .syndrome (w_syn),
        .parity   (w_par)
    );

    always_comb begin
        w_single = 1'b0;
        w_double = 1'b0;
        w_flip   = 1'b0;
        if (r_s1_mode == DEC && r_s1_syn != '0) begin
            if ({1'b0, r_s1_syn} > (PAR_W + 1)'(c_n_pos)) begin
                w_double = 1'b1;
`ifdef HAM_SECDED_EN
            end else if (r_s1_par) begin
                w_flip   = 1'b1;
                w_single = 1'b1;
            end else begin
                w_double = 1'b1;
            end
        end else if (r_s1_mode == DEC && r_s1_par) begin
            w_single = 1'b1;
        end
`else
            end else begin
                w_flip   = 1'b1;
                w_single = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        w_fixed = r_s1_word;
        for (int i = 0; i < c_n_pos; i++) begin
            if (w_flip && r_s1_syn == PAR_W'(i + 1)) w_fixed[i] = ~r_s1_word[i];
        end
    end

    // Syndrome of a zero-parity word is exactly the parity pattern to insert
    always_comb begin
        w_code = r_s1_word;
        for (int k = 0; k < PAR_W; k++) begin
            w_code[(1 << k) - 1] = r_s1_syn[k];
        end
`ifdef HAM_SECDED_EN
        w_code[CODE_W-1] = r_s1_par ^ (^r_s1_syn);
`endif
    end

    for (genvar j = 0; j < DATA_W; j++) begin : g_extract
        localparam int c_pos = data_pos(j);
        assign w_payload[j] = w_fixed[c_pos-1];
    end

    assign w_result = (r_s1_mode == DEC) ? CODE_W'(w_payload) : w_code;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_single <= 1'b0;
            r_out_double <= 1'b0;
        end else if (!w_stall) begin
            r_s1_valid   <= in_valid;
            r_s1_mode    <= in_mode;
            r_s1_word    <= w_s1_word;
            r_s1_syn     <= w_syn;
            r_s1_par     <= w_par;
            r_out_valid  <= r_s1_valid;
            r_out_data   <= w_result;
            r_out_single <= r_s1_valid && w_single;
            r_out_double <= r_s1_valid && w_double;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr_cnt) begin
            r_cnt_single <= '0;
            r_cnt_double <= '0;
        end else if (r_out_valid && out_ready) begin
            if (r_out_single && r_cnt_single != '1) r_cnt_single <= r_cnt_single + CNT_W'(1);
            if (r_out_double && r_cnt_double != '1) r_cnt_double <= r_cnt_double + CNT_W'(1);
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_single = r_out_single;
    assign out_double = r_out_double;
    assign cnt_single = r_cnt_single;
    assign cnt_double = r_cnt_double;

endmodule
`default_nettype wire

// File: tb/tb_ham_secded_codec.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ham_secded_codec                                                        |
// | Directed vectors plus a position-arithmetic reference model and scoreboard.|
// | Optional feature macro: HAM_SECDED_EN (selects the 16-bit code checks).    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ham_secded_codec;

    localparam int DW      = 11;
    localparam int NP      = 15;
    localparam int CNT_MAX = 15;
`ifdef HAM_SECDED_EN
    localparam int CW = 16;
    localparam logic [CW-1:0] L_ENC_A  = 16'hF834;
    localparam logic [CW-1:0] L_ENC_B  = 16'h8007;
    localparam logic [CW-1:0] L_DEC_1  = 16'hF824;
    localparam logic [CW-1:0] L_DEC_2  = 16'hF837;
    localparam logic [CW-1:0] L_OUT_2  = 16'h0787;
    localparam logic          L_S_2    = 1'b0;
    localparam logic          L_D_2    = 1'b1;
    localparam logic          L_S_3    = 1'b1;
    localparam int            L_CD_END = 1;
`else
    localparam int CW = 15;
    localparam logic [CW-1:0] L_ENC_A  = 15'h7834;
    localparam logic [CW-1:0] L_ENC_B  = 15'h0007;
    localparam logic [CW-1:0] L_DEC_1  = 15'h7824;
    localparam logic [CW-1:0] L_DEC_2  = 15'h7837;
    localparam logic [CW-1:0] L_OUT_2  = 15'h0786;
    localparam logic          L_S_2    = 1'b1;
    localparam logic          L_D_2    = 1'b0;
    localparam logic          L_S_3    = 1'b0;
    localparam int            L_CD_END = 0;
`endif

    typedef struct packed {
        logic [CW-1:0] data;
        logic          single;
        logic          dbl;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_mode = 1'b0;
    logic [CW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [CW-1:0] out_data;
    logic          out_single;
    logic          out_double;
    logic          clr_cnt = 1'b0;
    logic [3:0]    cnt_single;
    logic [3:0]    cnt_double;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q[$];
    int   m_cs = 0;
    int   m_cd = 0;
    logic prev_stall = 1'b0;
    exp_t prev_out;
    logic saw_stall = 1'b0;

    ham_secded_codec #(.DATA_W(DW), .CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mode    (in_mode),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_single (out_single),
        .out_double (out_double),
        .clr_cnt    (clr_cnt),
        .cnt_single (cnt_single),
        .cnt_double (cnt_double)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] m_encode(input logic [DW-1:0] d);
        logic [CW-1:0] cw;
        int s;
        int j;
        cw = '0;
        s  = 0;
        j  = 0;
        for (int pos = 1; pos <= NP; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos-1] = d[j];
                if (d[j]) s = s ^ pos;
                j++;
            end
        end
        for (int k = 0; k < 4; k++) cw[(1 << k) - 1] = s[k];
`ifdef HAM_SECDED_EN
        cw[CW-1] = ^cw[CW-2:0];
`endif
        return cw;
    endfunction

    function automatic exp_t m_model(input logic mode, input logic [CW-1:0] din);
        exp_t          e;
        logic [CW-1:0] cw;
        logic [DW-1:0] d;
        int            s;
        int            j;
        logic          p;
        e = '0;
        if (!mode) begin
            e.data = m_encode(din[DW-1:0]);
            return e;
        end
        s = 0;
        for (int pos = 1; pos <= NP; pos++) if (din[pos-1]) s = s ^ pos;
        p  = ^din;
        cw = din;
`ifdef HAM_SECDED_EN
        if (s == 0 && p) e.single = 1'b1;
        else if (s != 0 && p) begin cw[s-1] = ~cw[s-1]; e.single = 1'b1; end
        else if (s != 0) e.dbl = 1'b1;
`else
        if (s != 0) begin cw[s-1] = ~cw[s-1]; e.single = 1'b1; end
`endif
        j = 0;
        d = '0;
        for (int pos = 1; pos <= NP; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                d[j] = cw[pos-1];
                j++;
            end
        end
        e.data = CW'(d);
        return e;
    endfunction

    // Scoreboard, stall-stability and counter checks on every falling edge
    always @(negedge clk) begin
        exp_t e;
        logic fire;
        if (!rst_n) begin
            q.delete();
            m_cs = 0;
            m_cd = 0;
            prev_stall = 1'b0;
        end else begin
            chk("cnt_single", 32'(cnt_single), 32'(m_cs));
            chk("cnt_double", 32'(cnt_double), 32'(m_cd));
            chk("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            if (!in_ready) saw_stall = 1'b1;
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", {out_data, out_single, out_double}, {prev_out.data, prev_out.single, prev_out.dbl});
            end
            fire = out_valid && out_ready;
            e = '0;
            if (fire) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", 32'(q.size()), 32'd1);
                end else begin
                    e = q.pop_front();
                    chk("sb_data", 32'(out_data), 32'(e.data));
                    chk("sb_flags", {out_single, out_double}, {e.single, e.dbl});
                end
            end
            if (clr_cnt) begin
                m_cs = 0;
                m_cd = 0;
            end else if (fire) begin
                if (e.single && m_cs != CNT_MAX) m_cs++;
                if (e.dbl && m_cd != CNT_MAX) m_cd++;
            end
            if (in_valid && in_ready) q.push_back(m_model(in_mode, in_data));
            prev_stall = out_valid && !out_ready;
            prev_out   = '{data: out_data, single: out_single, dbl: out_double};
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_check(input logic mode, input logic [CW-1:0] din, input logic [CW-1:0] exp,
                              input logic es, input logic ed, input string nm);
        in_valid = 1'b1;
        in_mode  = mode;
        in_data  = din;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_lat1"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({nm, "_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_data"}, 32'(out_data), 32'(exp));
        chk({nm, "_flags"}, {out_single, out_double}, {es, ed});
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic mode, input logic [CW-1:0] din);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_mode  = mode;
        in_data  = din;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("push_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        idle(3);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out", {out_data, out_single, out_double}, 32'd0);
        chk("rst_cnts", {cnt_single, cnt_double}, 32'd0);
        @(posedge clk);
        #1;

        chk("model_enc_a", 32'(m_encode(11'b11110000111)), 32'(L_ENC_A));
        send_check(1'b0, CW'(11'b11110000111), L_ENC_A, 1'b0, 1'b0, "enc_a");
        send_check(1'b0, CW'(11'b00000000001), L_ENC_B, 1'b0, 1'b0, "enc_b");
        send_check(1'b1, L_DEC_1, CW'(11'b11110000111), 1'b1, 1'b0, "dec_single");
        @(negedge clk);
        chk("cnt_single_one", 32'(cnt_single), 32'd1);
        @(posedge clk);
        #1;
        send_check(1'b1, L_DEC_2, L_OUT_2, L_S_2, L_D_2, "dec_two");
        send_check(1'b1, CW'(15'h7834), CW'(11'b11110000111), L_S_3, 1'b0, "dec_7834");
        @(negedge clk);
        chk("cnt_single_end", 32'(cnt_single), 32'd2);
        chk("cnt_double_end", 32'(cnt_double), 32'(L_CD_END));
        @(posedge clk);
        #1;

        // Back-to-back mixed-mode stream with a 3-cycle downstream stall
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    if (i % 2 == 0) push(1'b0, CW'(11'(i * 37 + 5)));
                    else push(1'b1, m_encode(11'(i * 91 + 3)) ^ (CW'(1) << (i % CW)));
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(5);
        chk("stall_seen", 32'(saw_stall), 32'd1);
        chk("stream_drained", 32'(q.size()), 32'd0);

        for (int i = 0; i < 20; i++) push(1'b1, m_encode(11'(i * 13)) ^ (CW'(1) << 4));
        idle(4);
        chk("cnt_saturated", 32'(cnt_single), 32'd15);

        // Clear in the same cycle a single-error result is delivered
        in_valid = 1'b1;
        in_mode  = 1'b1;
        in_data  = L_DEC_1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        clr_cnt = 1'b1;
        @(negedge clk);
        chk("clr_collide_setup", {out_valid, out_single}, 2'b11);
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        @(negedge clk);
        chk("clr_priority", {cnt_single, cnt_double}, 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) push(1'b1, L_DEC_1);
        for (int i = 0; i < 2; i++) push(1'b0, CW'(11'(i + 100)));
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_cnts", {cnt_single, cnt_double}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_flush1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("midrst_flush2", 32'(out_valid), 32'd0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ham_secded_codec.md
# ham_secded_codec

Parametrised, pipelined Hamming codec for streaming data. It generalises the fixed 11-to-15 Hamming encoder to any data width and supports both encode and decode per transaction. It adds optional SECDED (extended parity), single-bit correction, double-error detection, a valid/ready handshake and saturating error counters. It sits on the register-file / memory write and read paths of the CPU datapath.

## Interface
- DATA_W, default 11: payload width, 4..57.
- PAR_W, derived, not overridable: smallest p with 2^p >= DATA_W+p+1; 4 for DATA_W=11.
- CODE_W, derived: DATA_W+PAR_W+1 with HAM_SECDED_EN, DATA_W+PAR_W without; 16 or 15 at default.
- CNT_W, default 16: error counter width.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  codec accepts the beat this cycle.
- in_mode  in  1  0 = encode, 1 = decode; sampled with the beat.
- in_data  in  CODE_W  encode: payload in [DATA_W-1:0], upper bits ignored; decode: received codeword.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_data  out  CODE_W  encode: codeword; decode: corrected payload in [DATA_W-1:0], upper bits zero.
- out_single  out  1  decode only: single error corrected.
- out_double  out  1  decode only: uncorrectable error; payload passed through uncorrected.
- clr_cnt  in  1  synchronous clear of both counters.
- cnt_single  out  CNT_W  saturating count of delivered out_single results.
- cnt_double  out  CNT_W  saturating count of delivered out_double results.

## Operation
- Codeword layout:
  - out_data bit i holds Hamming position i+1.
  - Parity bits sit at power-of-two positions.
  - Data bits d0..d(DATA_W-1) fill the remaining positions in ascending order.
  - Parity p(2^k) is even parity over all positions with bit k set.
  - The extended parity bit (HAM_SECDED_EN only) is bit CODE_W-1 and makes total codeword parity even.
- Encode: compute parity, assemble the codeword. out_single and out_double are 0.
- Decode:
  - syndrome S = XOR of the positions of set bits; P = XOR of all CODE_W bits.
  - S=0, P=0: no error.
  - S!=0, P=1: flip position S, out_single=1.
  - S=0, P=1: extended bit in error, out_single=1, data unchanged.
  - S!=0, P=0: out_double=1, no correction.
  - S > DATA_W+PAR_W: out_double=1 in both configurations.
- Counters:
  - Increment on out_valid&&out_ready when the matching flag is set.
  - Saturate at all-ones.
  - clr_cnt has priority over a simultaneous increment.

## Timing
- Two-stage pipeline.
  - Stage 1 registers the beat and the syndrome/parity.
  - Stage 2 registers the corrected or assembled result.
- Latency: 2 cycles from in handshake to out_valid when out_ready=1; throughput 1 beat/cycle.
- Global stall:
  - in_ready = !(out_valid && !out_ready); both stages hold when stalled.
  - out_data and the flags stay stable while out_valid && !out_ready.
- Bubbles in stage 1 are not collapsed.
- Reset values: in_ready=1 after reset; out_valid, out_data, out_single, out_double, cnt_single and cnt_double are all 0.
- Reset mid-stream discards both stage contents; no partial beat is emitted.
- Mode may change on every beat; there is no turnaround cycle.

## Configuration
- HAM_SECDED_EN defined: extended parity bit present, CODE_W = DATA_W+PAR_W+1, double-error detection as above.
- HAM_SECDED_EN undefined:
  - Plain SEC, CODE_W = DATA_W+PAR_W.
  - Any S!=0 within range is corrected and flagged out_single.
  - out_double asserts only for an out-of-range S.

## Structure
- Package ham_pkg holds:
  - functions ham_par_w(data_w), ham_code_w(data_w) and is_pow2(pos);
  - a function mapping data index to codeword position;
  - the localparam mode encodings ENC=0, DEC=1.
- Sub-module ham_syndrome: combinational; takes a position-ordered word and returns the PAR_W syndrome and overall parity. It is shared by the encode and decode paths in stage 1.

## Test plan
- Encode data 11'b11110000111 -> out_data 16'hF834, flags 0, out_valid exactly 2 cycles after the handshake. Without the macro, the result is 15'h7834.
- Encode 11'b00000000001 -> 16'h8007; without the macro, 15'h0007.
- Decode 16'hF824 (position 5 flipped) -> out_data 11'b11110000111, out_single=1, cnt_single=1.
- Decode 16'hF837 (positions 1,2 flipped) -> out_double=1, out_data[10:0] = uncorrected payload, cnt_double=1. Decode 16'h7834 -> out_single=1, payload 11'b11110000111.
- Back-to-back beats with out_ready held low for 3 cycles -> in_ready low after the pipeline fills, out_data stable, no beat lost or duplicated, order preserved.
- Force cnt_single to all-ones then deliver a single error -> counter stays saturated. clr_cnt asserted in the same cycle as an increment -> 0. rst_n low mid-stream -> out_valid=0 next cycle, counters 0.
